ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32IM pipeline; sits between ID and the memory stage.
- Computes the ALU/multiply result, load/store address and store data, then registers them into the EX/MEM pipeline register that drives the memory stage's alu_result, rs2_data, mem_read and mem_write inputs.
- DIV/DIVU/REM/REMU use a multi-cycle iterative divider and stall upstream while it runs; every other op completes in one cycle.

---
 rtl/ex_pkg.sv | 40 ++++
 rtl/ex_stage_if.sv | 42 ++++
 rtl/ex_stage_div_unit.sv | 122 ++++++++++++
 rtl/ex_stage.sv | 123 ++++++++++++
 tb/tb_ex_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the RV32IM execute stage.
//   - alu_op encodings (ALU_ADD .. ALU_REMU)
//   - divider FSM state encoding
//   - divider iteration count and op-class helpers
package ex_pkg;

  localparam int XLEN     = 32;
  localparam int DIV_ITER = 32;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASSB  = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, flush/stall handshake and EX/MEM outputs of the
// execute stage.
//   master : ID/hazard side (drives id_*, flush; sees ex_busy, exm_*)
//   slave  : ex_stage itself
interface ex_stage_if #(parameter int XLEN = 32);

  logic            id_valid;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_alu_src;
  logic [4:0]      id_alu_op;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_reg_write;
  logic [4:0]      id_rd;
  logic            flush;

  logic            ex_busy;
  logic            exm_valid;
  logic [XLEN-1:0] exm_alu_result;
  logic [XLEN-1:0] exm_rs2_data;
  logic            exm_mem_read;
  logic            exm_mem_write;
  logic            exm_reg_write;
  logic [4:0]      exm_rd;

  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write, id_rd, flush,
    input  ex_busy, exm_valid, exm_alu_result, exm_rs2_data, exm_mem_read,
           exm_mem_write, exm_reg_write, exm_rd
  );

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write, id_rd, flush,
    output ex_busy, exm_valid, exm_alu_result, exm_rs2_data, exm_mem_read,
           exm_mem_write, exm_reg_write, exm_rd
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU/REM/REMU.
//   clk, rst_n : clock, async active-low reset
//   start      : valid div op in EX (already gated with flush by caller)
//   signed_op  : DIV/REM
//   rem_op     : REM/REMU (return remainder instead of quotient)
//   a, b       : dividend, divisor
//   flush      : abort any divide in flight
//   busy       : stall request (acceptance cycle and RUN)
//   done       : result valid this cycle (special case in IDLE, or DONE)
//   result     : quotient or remainder
// Divide-by-zero and signed overflow finish combinationally without the FSM.
module div_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signed_op,
  input  logic            rem_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            q_neg_q, r_neg_q, rem_op_q;

  logic            a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, spec_result, corrected;
  logic [XLEN:0]   shifted, diff;
  logic            ge;

  assign a_neg   = signed_op & a[XLEN-1];
  assign b_neg   = signed_op & b[XLEN-1];
  assign a_abs   = a_neg ? -a : a;
  assign b_abs   = b_neg ? -b : b;
  assign div0    = (b == '0);
  assign ovf     = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign special = div0 | ovf;

  // Overflow quotient equals the dividend (0x80000000), remainder is zero.
  assign spec_result = div0 ? (rem_op ? a : '1) : (rem_op ? '0 : a);

  // One restoring step: shift next dividend bit into the partial remainder.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[XLEN];

  assign corrected = rem_op_q ? (r_neg_q ? -rem_q : rem_q)
                              : (q_neg_q ? -quo_q : quo_q);
  assign result    = (state_q == DIV_IDLE) ? spec_result : corrected;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          if (special) begin
            done = 1'b1;
          end else begin
            busy    = 1'b1;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        busy = 1'b1;
        if (cnt_q == 6'd1) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        // Leave on the capture edge so the held instruction is not re-accepted.
        done    = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush) begin
      state_d = DIV_IDLE;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rem_op_q <= 1'b0;
    end else if (state_q == DIV_IDLE && state_d == DIV_RUN) begin
      cnt_q    <= 6'(DIV_ITER);
      quo_q    <= a_abs;
      rem_q    <= '0;
      dvs_q    <= b_abs;
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
      rem_op_q <= rem_op;
    end else if (state_q == DIV_RUN) begin
      cnt_q <= cnt_q - 6'd1;
      quo_q <= {quo_q[XLEN-2:0], ge};
      rem_q <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage with EX/MEM pipeline register.
//   clk, rst_n : clock, async active-low reset
//   bus        : ex_stage_if.slave
//     in : id_valid, id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op,
//          id_mem_read, id_mem_write, id_reg_write, id_rd, flush
//     out: ex_busy, exm_valid, exm_alu_result, exm_rs2_data, exm_mem_read,
//          exm_mem_write, exm_reg_write, exm_rd
// ALU and multiply finish in one cycle; divides run on div_unit and hold
// ex_busy while iterating.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_stage_if.slave    bus
);

  logic [XLEN-1:0] op_a, op_b, alu_res, div_res;
  logic [4:0]      op, shamt;
  logic            is_div, div_start, div_busy, div_done, accept;
  logic            div_signed, div_rem;
  logic            ma_sx, mb_sx;
  logic [63:0]     ma, mb, prod;

  logic            exm_valid_q, exm_mr_q, exm_mw_q, exm_rw_q;
  logic [XLEN-1:0] exm_res_q, exm_rs2_q;
  logic [4:0]      exm_rd_q;

  assign op    = bus.id_alu_op;
  assign op_a  = bus.id_rs1_data;
  assign op_b  = bus.id_alu_src ? bus.id_imm : bus.id_rs2_data;
  assign shamt = op_b[4:0];

  // Multiply: sign/zero-extend to 64 bits; low 64 bits of the product are
  // exact for every 33x33 signed combination.
  assign ma_sx = (op != ALU_MULHU) & op_a[XLEN-1];
  assign mb_sx = ((op == ALU_MUL) || (op == ALU_MULH)) & op_b[XLEN-1];
  assign ma    = {{(64-XLEN){ma_sx}}, op_a};
  assign mb    = {{(64-XLEN){mb_sx}}, op_b};
  assign prod  = ma * mb;

  assign is_div     = is_div_op(op);
  assign div_start  = bus.id_valid & is_div & ~bus.flush;
  assign div_signed = (op == ALU_DIV) || (op == ALU_REM);
  assign div_rem    = (op == ALU_REM) || (op == ALU_REMU);

  div_unit #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .signed_op (div_signed),
    .rem_op    (div_rem),
    .a         (op_a),
    .b         (op_b),
    .flush     (bus.flush),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_res)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SLT:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:   alu_res = XLEN'(op_a < op_b);
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_PASSB:  alu_res = op_b;
      ALU_MUL:    alu_res = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res = prod[63:32];
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:   alu_res = div_done ? div_res : '0;
      default:    alu_res = '0;
    endcase
  end

  // A div op with busy low is always either a special case or in DONE.
  assign accept = bus.id_valid & ~bus.flush & ~div_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_valid_q <= 1'b0;
      exm_mr_q    <= 1'b0;
      exm_mw_q    <= 1'b0;
      exm_rw_q    <= 1'b0;
      exm_rd_q    <= '0;
      exm_res_q   <= '0;
      exm_rs2_q   <= '0;
    end else begin
      exm_valid_q <= accept;
      exm_mr_q    <= accept & bus.id_mem_read;
      exm_mw_q    <= accept & bus.id_mem_write;
      exm_rw_q    <= accept & bus.id_reg_write;
      if (accept) begin
        exm_rd_q  <= bus.id_rd;
        exm_res_q <= alu_res;
        exm_rs2_q <= bus.id_rs2_data;
      end
    end
  end

  assign bus.ex_busy        = div_busy;
  assign bus.exm_valid      = exm_valid_q;
  assign bus.exm_alu_result = exm_res_q;
  assign bus.exm_rs2_data   = exm_rs2_q;
  assign bus.exm_mem_read   = exm_mr_q;
  assign bus.exm_mem_write  = exm_mw_q;
  assign bus.exm_reg_write  = exm_rw_q;
  assign bus.exm_rd         = exm_rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if bus();

  ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, imm;
    logic        src;
    logic [31:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, b, imm,
                       input logic src, mr, mw, rw, input logic [4:0] rd);
    bus.id_valid = 1'b1;  bus.id_alu_op = op;
    bus.id_rs1_data = a;  bus.id_rs2_data = b;  bus.id_imm = imm;
    bus.id_alu_src = src; bus.id_mem_read = mr; bus.id_mem_write = mw;
    bus.id_reg_write = rw; bus.id_rd = rd;
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_alu_op = ALU_ADD;
    bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
    bus.id_alu_src = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
    bus.id_reg_write = 1'b0; bus.id_rd = '0;
    #1;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0;
    idle();
    total++; if (bus.exm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.exm_valid); end
    total++; if (bus.exm_alu_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.exm_alu_result); end
    total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.ex_busy); end
    rst_n = 1'b1;
    step();
    drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5);
    step();
    total++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== 32'd3) begin bad++; $display("FAIL pre_reset_add got=%b/%h exp=1/3", bus.exm_valid, bus.exm_alu_result); end
    // async reset mid-stream, checked before the next edge
    rst_n = 1'b0;
    #1;
    total++; if ({bus.exm_valid, bus.exm_mem_read, bus.exm_mem_write, bus.exm_reg_write} !== 4'b0) begin bad++; $display("FAIL async_reset_ctrl got=%b exp=0000", {bus.exm_valid, bus.exm_mem_read, bus.exm_mem_write, bus.exm_reg_write}); end
    total++; if (bus.exm_alu_result !== 32'h0 || bus.exm_rd !== 5'd0) begin bad++; $display("FAIL async_reset_data got=%h/%0d exp=0/0", bus.exm_alu_result, bus.exm_rd); end
    // reset mid-divide must abort the FSM
    idle();
    rst_n = 1'b1;
    step();
    drive(ALU_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    step(); step(); step();
    total++; if (bus.ex_busy !== 1'b1) begin bad++; $display("FAIL div_running got=%b exp=1", bus.ex_busy); end
    rst_n = 1'b0;
    idle();
    total++; if (bus.ex_busy !== 1'b0 || bus.exm_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_div got=%b/%b exp=0/0", bus.ex_busy, bus.exm_valid); end
    rst_n = 1'b1;
    step();
    total++; if (bus.ex_busy !== 1'b0 || bus.exm_valid !== 1'b0) begin bad++; $display("FAIL after_reset_div got=%b/%b exp=0/0", bus.ex_busy, bus.exm_valid); end
  endtask

  task automatic test_alu();
    vec_t v[12];
    v = '{
      '{ALU_ADD,   32'h7,        32'hFFFFFFFD, 32'h0,        1'b0, 32'h00000004},
      '{ALU_SRA,   32'h80000000, 32'h0,        32'h4,        1'b1, 32'hF8000000},
      '{ALU_SUB,   32'h5,        32'h7,        32'h0,        1'b0, 32'hFFFFFFFE},
      '{ALU_SLT,   32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 32'h00000001},
      '{ALU_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 32'h00000000},
      '{ALU_SLL,   32'h1,        32'd31,       32'h0,        1'b0, 32'h80000000},
      '{ALU_SRL,   32'h80000000, 32'h0,        32'h24,       1'b1, 32'h08000000},
      '{ALU_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        1'b0, 32'h0FF00FF0},
      '{ALU_OR,    32'h0F,       32'hF0,       32'h0,        1'b0, 32'h000000FF},
      '{ALU_AND,   32'hF0F0,     32'hFF00,     32'h0,        1'b0, 32'h0000F000},
      '{ALU_PASSB, 32'h1,        32'h2,        32'h12345000, 1'b1, 32'h12345000},
      '{5'd25,     32'h1234,     32'h5678,     32'h0,        1'b0, 32'h00000000}
    };
    // back-to-back issue, one result per edge
    for (int i = 0; i < 12; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].src, 1'b0, 1'b0, 1'b1, 5'(i + 1));
      step();
      total++; if (bus.exm_alu_result !== v[i].exp || bus.exm_valid !== 1'b1 || bus.exm_rd !== 5'(i + 1))
        begin bad++; $display("FAIL alu_vec%0d op=%0d got=%h/%b/%0d exp=%h/1/%0d", i, v[i].op, bus.exm_alu_result, bus.exm_valid, bus.exm_rd, v[i].exp, i + 1); end
    end
    drive(ALU_ADD, 32'h100, 32'hDEADBEEF, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    total++; if (bus.exm_alu_result !== 32'h108) begin bad++; $display("FAIL store_addr got=%h exp=00000108", bus.exm_alu_result); end
    total++; if (bus.exm_rs2_data !== 32'hDEADBEEF) begin bad++; $display("FAIL store_data got=%h exp=deadbeef", bus.exm_rs2_data); end
    total++; if ({bus.exm_mem_write, bus.exm_mem_read, bus.exm_reg_write} !== 3'b100) begin bad++; $display("FAIL store_ctrl got=%b exp=100", {bus.exm_mem_write, bus.exm_mem_read, bus.exm_reg_write}); end
    idle();
    step();
    total++; if (bus.exm_valid !== 1'b0 || bus.exm_mem_write !== 1'b0) begin bad++; $display("FAIL bubble got=%b/%b exp=0/0", bus.exm_valid, bus.exm_mem_write); end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [4] = '{ALU_MULH, ALU_MULHU, ALU_MUL, ALU_MULHSU};
    logic [31:0] exps[4] = '{32'h00000000, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
      step();
      total++; if (bus.exm_alu_result !== exps[i] || bus.exm_valid !== 1'b1)
        begin bad++; $display("FAIL mul_op%0d got=%h exp=%h", ops[i], bus.exm_alu_result, exps[i]); end
    end
    idle();
  endtask

  task automatic run_div(input logic [4:0] op, input logic [31:0] a, b, exp);
    int cyc;
    int bubble_err;
    drive(op, a, b, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11);
    total++; if (bus.ex_busy !== 1'b1) begin bad++; $display("FAIL div_accept_busy op=%0d got=%b exp=1", op, bus.ex_busy); end
    cyc = 1;
    bubble_err = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ex_busy !== 1'b1) break;
      cyc++;
      if (bus.exm_valid !== 1'b0) bubble_err++;
    end
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_busy_cycles op=%0d got=%0d exp=33", op, cyc); end
    total++; if (bubble_err !== 0 || bus.exm_valid !== 1'b0) begin bad++; $display("FAIL div_run_bubble op=%0d got=%0d exp=0", op, bubble_err); end
    step();
    total++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== exp || bus.exm_rd !== 5'd11)
      begin bad++; $display("FAIL div_result op=%0d got=%b/%h/%0d exp=1/%h/11", op, bus.exm_valid, bus.exm_alu_result, bus.exm_rd, exp); end
    // next instruction follows directly and issues once
    drive(ALU_ADD, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12);
    total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL div_follow_busy got=%b exp=0", bus.ex_busy); end
    step();
    total++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== 32'd30 || bus.exm_rd !== 5'd12)
      begin bad++; $display("FAIL div_follow got=%b/%h exp=1/0000001e", bus.exm_valid, bus.exm_alu_result); end
    idle();
    step();
    total++; if (bus.exm_valid !== 1'b0 || bus.ex_busy !== 1'b0) begin bad++; $display("FAIL div_once got=%b/%b exp=0/0", bus.exm_valid, bus.ex_busy); end
  endtask

  task automatic test_div();
    run_div(ALU_DIV,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2);
    run_div(ALU_REM,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE);
    run_div(ALU_DIVU, 32'hFFFFFF9C, 32'd7, 32'h24924916);
  endtask

  task automatic test_div_special();
    vec_t v[6];
    v = '{
      '{ALU_DIVU, 32'd5,        32'd0,        32'h0, 1'b0, 32'hFFFFFFFF},
      '{ALU_REMU, 32'd5,        32'd0,        32'h0, 1'b0, 32'h00000005},
      '{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h80000000},
      '{ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h00000000},
      '{ALU_DIV,  32'hFFFFFFFB, 32'd0,        32'h0, 1'b0, 32'hFFFFFFFF},
      '{ALU_REM,  32'hFFFFFFFB, 32'd0,        32'h0, 1'b0, 32'hFFFFFFFB}
    };
    for (int i = 0; i < 6; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].src, 1'b0, 1'b0, 1'b1, 5'd7);
      total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL spec_busy%0d got=%b exp=0", i, bus.ex_busy); end
      step();
      total++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== v[i].exp)
        begin bad++; $display("FAIL spec_div%0d got=%b/%h exp=1/%h", i, bus.exm_valid, bus.exm_alu_result, v[i].exp); end
    end
    idle();
  endtask

  task automatic test_flush();
    drive(ALU_DIV, 32'd1000, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
    for (int i = 0; i < 10; i++) step();
    total++; if (bus.ex_busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy got=%b exp=1", bus.ex_busy); end
    bus.flush = 1'b1;
    #1;
    total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL flush_busy_drop got=%b exp=0", bus.ex_busy); end
    step();
    total++; if ({bus.exm_valid, bus.exm_reg_write, bus.exm_mem_read, bus.exm_mem_write} !== 4'b0)
      begin bad++; $display("FAIL flush_exm got=%b exp=0000", {bus.exm_valid, bus.exm_reg_write, bus.exm_mem_read, bus.exm_mem_write}); end
    bus.flush = 1'b0;
    idle();
    total++; if (bus.ex_busy !== 1'b0) begin bad++; $display("FAIL flush_fsm_idle got=%b exp=0", bus.ex_busy); end
    drive(ALU_ADD, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
    step();
    total++; if (bus.exm_valid !== 1'b1 || bus.exm_alu_result !== 32'd3) begin bad++; $display("FAIL flush_after_add got=%b/%h exp=1/3", bus.exm_valid, bus.exm_alu_result); end
    // flush on a single-cycle load kills it
    drive(ALU_ADD, 32'h40, 32'h0, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8);
    bus.flush = 1'b1;
    step();
    total++; if ({bus.exm_valid, bus.exm_mem_read, bus.exm_reg_write} !== 3'b0) begin bad++; $display("FAIL flush_load got=%b exp=000", {bus.exm_valid, bus.exm_mem_read, bus.exm_reg_write}); end
    bus.flush = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
